// File: rtl/lsu_dmem_master.sv
// RV32I load/store initiator for a word-only data memory: sub-word extraction on loads, read-modify-write for sb/sh.
// Define MISALIGN_TRAP_EN to reject misaligned lh/lhu/sh/lw/sw with an error response.
module lsu_dmem_master #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);
    // Handshake: a request transfers on a rising edge where req_valid && req_ready; there is no response backpressure.
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH_WORDS);

    state_t      state;
    logic        l_we;
    logic [2:0]  l_f3;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] merge_q;

    logic        f3_ok, range_ok, align_ok, req_ok;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;
    logic        is_sw;

    always_comb begin
        f3_ok    = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        range_ok = {2'b00, req_addr[31:2]} < DEPTH_W;
`ifdef MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   align_ok = ~req_addr[0];
            2'b10:   align_ok = (req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
`else
        align_ok = 1'b1;
`endif
        req_ok = f3_ok && range_ok && align_ok;
    end

    // Lane selection uses the latched address; memory read data is valid throughout ACCESS.
    always_comb begin
        byte_sel = mem_rd[{l_addr[1:0], 3'b000} +: 8];
        half_sel = l_addr[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (l_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'h0, byte_sel};
            3'b101:  load_val = {16'h0, half_sel};
            default: load_val = mem_rd;
        endcase
        merged = mem_rd;
        if (l_f3[1:0] == 2'b00)
            merged[{l_addr[1:0], 3'b000} +: 8] = l_wdata[7:0];
        else
            merged[{l_addr[1], 4'b0000} +: 16] = l_wdata[15:0];
    end

    // Memory-side outputs decode straight from flops so an async reset kills a write at once.
    assign is_sw     = l_we && (l_f3 == 3'b010);
    assign mem_a     = (state == S_ACCESS || state == S_MERGE) ? {l_addr[31:2], 2'b00} : 32'h0;
    assign mem_we    = (state == S_ACCESS && is_sw) || (state == S_MERGE);
    assign mem_wd    = (state == S_ACCESS && is_sw) ? l_wdata :
                       (state == S_MERGE)           ? merge_q : 32'h0;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            l_we      <= 1'b0;
            l_f3      <= 3'b000;
            l_addr    <= 32'h0;
            l_wdata   <= 32'h0;
            merge_q   <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        l_we      <= req_we;
                        l_f3      <= req_funct3;
                        l_addr    <= req_addr;
                        l_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_ok) begin
                            state <= S_ACCESS;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!l_we) begin
                        rsp_rdata <= load_val;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (is_sw) begin
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        merge_q <= merged;
                        state   <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule
